// File: rtl/disp_mode_ctrl_if.sv
// Bundle of key, display-source, event and control signals for the clock mode sequencer.
// The DUT uses the slave modport; the master modport is the key/datapath side that drives it.
interface disp_mode_ctrl_if;
  logic        key_mode;
  logic        key_sel;
  logic        key_up;
  logic        key_dn;
  logic [31:0] clk_data;
  logic [31:0] cal_data;
  logic [31:0] alm_data;
  logic [31:0] cd_data;
  logic        alarm_hit;
  logic        cd_done;
  logic [31:0] disp_data;
  logic [2:0]  mode;
  logic [1:0]  field;
  logic [2:0]  tgt;
  logic        inc_req;
  logic        dec_req;
  logic        cd_run;
  logic        buzzer;

  modport master (
    output key_mode, key_sel, key_up, key_dn,
    output clk_data, cal_data, alm_data, cd_data,
    output alarm_hit, cd_done,
    input  disp_data, mode, field, tgt, inc_req, dec_req, cd_run, buzzer
  );

  modport slave (
    input  key_mode, key_sel, key_up, key_dn,
    input  clk_data, cal_data, alm_data, cd_data,
    input  alarm_hit, cd_done,
    output disp_data, mode, field, tgt, inc_req, dec_req, cd_run, buzzer
  );
endinterface

// File: rtl/disp_mode_ctrl.sv
// Mode sequencer and display arbiter for the electronic clock: key decode, field edit
// requests, blink overlay, idle auto-exit and alarm/countdown ringing with timeout.
//
// state        | meaning
// CLOCK        | show time
// CLOCK_SET    | edit time (fields sec/min/hr)
// CALENDAR     | show date
// CALENDAR_SET | edit date (three fields)
// ALARM_SET    | edit alarm (min, hr)
// COUNTDOWN    | show countdown; sel starts/stops, up/dn edit while stopped
module disp_mode_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HALF = 12_500_000,
  parameter int IDLE_S     = 10,
  parameter int RING_S     = 30
) (
  input logic             Clk,
  input logic             Reset_n,
  disp_mode_ctrl_if.slave bus
);

  localparam int PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BLK_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int SEC_MAX = (IDLE_S > RING_S) ? IDLE_S : RING_S;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

  localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(CLK_HZ - 1);
  localparam logic [BLK_W-1:0] BLK_TC  = BLK_W'(BLINK_HALF - 1);
  localparam logic [SEC_W-1:0] IDLE_TC = SEC_W'(IDLE_S - 1);
  localparam logic [SEC_W-1:0] RING_TC = SEC_W'(RING_S - 1);
  localparam logic [31:0]      BLANK   = 32'hBBBB_BBBB;

  typedef enum logic [2:0] {
    CLOCK        = 3'd0,
    CLOCK_SET    = 3'd1,
    CALENDAR     = 3'd2,
    CALENDAR_SET = 3'd3,
    ALARM_SET    = 3'd4,
    COUNTDOWN    = 3'd5
  } mode_t;

  mode_t            mode_q, mode_nx;
  logic [1:0]       field_q, field_nx;
  logic             cd_run_q, cd_run_nx;
  logic             ring_q, ring_nx;
  logic             ring_alm_q, ring_alm_nx;
  logic             inc_q, inc_nx;
  logic             dec_q, dec_nx;
  logic [31:0]      disp_q, disp_nx;
  logic             blink_ph_q;
  logic [BLK_W-1:0] blink_cnt_q;
  logic [PRE_W-1:0] idle_pre_q, ring_pre_q;
  logic [SEC_W-1:0] idle_sec_q, ring_sec_q;

  logic        key_any, hit, set_mode, editable, idle_tc, ring_tc, mode_chg;
  logic [31:0] src, mask;
  logic [2:0]  tgt;

  assign key_any  = bus.key_mode | bus.key_sel | bus.key_up | bus.key_dn;
  assign hit      = bus.alarm_hit | bus.cd_done;
  assign set_mode = (mode_q == CLOCK_SET) || (mode_q == CALENDAR_SET) || (mode_q == ALARM_SET);
  assign editable = set_mode || ((mode_q == COUNTDOWN) && !cd_run_q);
  assign idle_tc  = set_mode && !ring_q && !key_any &&
                    (idle_pre_q == PRE_TC) && (idle_sec_q == IDLE_TC);
  assign ring_tc  = ring_q && !key_any && (ring_pre_q == PRE_TC) && (ring_sec_q == RING_TC);
  assign mode_chg = (mode_nx != mode_q);

  always_comb begin
    mode_nx     = mode_q;
    field_nx    = field_q;
    cd_run_nx   = cd_run_q;
    ring_nx     = ring_q;
    ring_alm_nx = ring_alm_q;
    inc_nx      = 1'b0;
    dec_nx      = 1'b0;
    // While ringing, a key press only silences the ring.
    if (ring_q) begin
      if (key_any || ring_tc) ring_nx = 1'b0;
    end else if (bus.key_mode) begin
      field_nx = 2'd0;
      case (mode_q)
        CLOCK:        mode_nx = CLOCK_SET;
        CLOCK_SET:    mode_nx = CALENDAR;
        CALENDAR:     mode_nx = CALENDAR_SET;
        CALENDAR_SET: mode_nx = ALARM_SET;
        ALARM_SET:    mode_nx = COUNTDOWN;
        default:      mode_nx = CLOCK;
      endcase
    end else if (bus.key_sel) begin
      case (mode_q)
        CLOCK_SET, CALENDAR_SET: field_nx = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
        ALARM_SET:               field_nx = (field_q == 2'd0) ? 2'd1 : 2'd0;
        COUNTDOWN:               cd_run_nx = ~cd_run_q;
        default:                 field_nx = field_q;
      endcase
    end else if (editable) begin
      inc_nx = bus.key_up;
      dec_nx = ~bus.key_up & bus.key_dn;
    end
    if (idle_tc) begin
      mode_nx  = (mode_q == CALENDAR_SET) ? CALENDAR : CLOCK;
      field_nx = 2'd0;
    end
    if (mode_q > COUNTDOWN) begin
      mode_nx  = CLOCK;
      field_nx = 2'd0;
    end
    // A new hit wins over a same-cycle dismiss and restarts the ring.
    if (hit) begin
      ring_nx     = 1'b1;
      ring_alm_nx = bus.alarm_hit;
    end
    if (bus.cd_done) cd_run_nx = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q     <= CLOCK;
      field_q    <= 2'd0;
      cd_run_q   <= 1'b0;
      ring_q     <= 1'b0;
      ring_alm_q <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      disp_q     <= 32'd0;
    end else begin
      mode_q     <= mode_nx;
      field_q    <= field_nx;
      cd_run_q   <= cd_run_nx;
      ring_q     <= ring_nx;
      ring_alm_q <= ring_alm_nx;
      inc_q      <= inc_nx;
      dec_q      <= dec_nx;
      disp_q     <= disp_nx;
    end
  end

  always_comb begin
    mask = 32'd0;
    case (mode_q)
      CLOCK_SET: begin
        case (field_q)
          2'd0:    mask = 32'hFF00_0000;
          2'd1:    mask = 32'h000F_F000;
          2'd2:    mask = 32'h0000_00FF;
          default: mask = 32'd0;
        endcase
      end
      CALENDAR_SET: begin
        case (field_q)
          2'd0:    mask = 32'hFF00_0000;
          2'd1:    mask = 32'h00FF_0000;
          2'd2:    mask = 32'h0000_FFFF;
          default: mask = 32'd0;
        endcase
      end
      ALARM_SET: mask = (field_q == 2'd0) ? 32'h000F_F000 : 32'h0000_00FF;
      default:   mask = 32'd0;
    endcase
  end

  always_comb begin
    src = bus.clk_data;
    tgt = 3'd0;
    case (mode_q)
      CALENDAR, CALENDAR_SET: begin src = bus.cal_data; tgt = 3'd1; end
      ALARM_SET:              begin src = bus.alm_data; tgt = 3'd2; end
      COUNTDOWN:              begin src = bus.cd_data;  tgt = 3'd3; end
      default:                begin src = bus.clk_data; tgt = 3'd0; end
    endcase
    if (ring_q)
      disp_nx = blink_ph_q ? BLANK : (ring_alm_q ? bus.alm_data : bus.cd_data);
    else if (blink_ph_q)
      disp_nx = (src & ~mask) | (BLANK & mask);
    else
      disp_nx = src;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_ph_q  <= 1'b0;
      blink_cnt_q <= '0;
    end else if (key_any) begin
      blink_ph_q  <= 1'b0;
      blink_cnt_q <= '0;
    end else if (blink_cnt_q == BLK_TC) begin
      blink_ph_q  <= ~blink_ph_q;
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLK_W'(1);
    end
  end

  // Idle timer holds its count while ringing so a ring does not eat edit time.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idle_pre_q <= '0;
      idle_sec_q <= '0;
    end else if (!set_mode || key_any || mode_chg) begin
      idle_pre_q <= '0;
      idle_sec_q <= '0;
    end else if (!ring_q) begin
      if (idle_pre_q == PRE_TC) begin
        idle_pre_q <= '0;
        idle_sec_q <= idle_sec_q + SEC_W'(1);
      end else begin
        idle_pre_q <= idle_pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ring_pre_q <= '0;
      ring_sec_q <= '0;
    end else if (hit || !ring_q || key_any || ring_tc) begin
      ring_pre_q <= '0;
      ring_sec_q <= '0;
    end else if (ring_pre_q == PRE_TC) begin
      ring_pre_q <= '0;
      ring_sec_q <= ring_sec_q + SEC_W'(1);
    end else begin
      ring_pre_q <= ring_pre_q + PRE_W'(1);
    end
  end

  assign bus.disp_data = disp_q;
  assign bus.mode      = mode_q;
  assign bus.field     = field_q;
  assign bus.tgt       = tgt;
  assign bus.inc_req   = inc_q;
  assign bus.dec_req   = dec_q;
  assign bus.cd_run    = cd_run_q;
  assign bus.buzzer    = ring_q;

endmodule
